soc_hash_host: RTL and testbench

SOC_HASH_HOST -- requirements
Module: soc_hash_host

---
 rtl/soc_hash_host_pkg.sv | 28 ++
 rtl/soc_hash_host_if.sv | 27 ++
 rtl/soc_hash_host.sv | 160 ++++++++++++++++
 tb/tb_soc_hash_host.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_hash_host_pkg.sv
// Shared constants, state encoding and helpers for the soc_hash_host block.
package soc_hash_host_pkg;

    localparam int DEF_MSG_BYTES = 32;
    localparam int DEF_DIG_BYTES = 32;
    localparam int DEF_GUARD     = 2;
    localparam int DEF_TMO       = 4096;
    localparam int BYTE_W        = 8;

    // Encoding is fixed so the debug state output stays stable across builds.
    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_LOAD    = 4'd1,
        ST_START   = 4'd2,
        ST_GUARD   = 4'd3,
        ST_WAIT    = 4'd4,
        ST_RD_REQ  = 4'd5,
        ST_RD_CAP  = 4'd6,
        ST_RD_PUSH = 4'd7,
        ST_WRAP    = 4'd8,
        ST_ERR     = 4'd9
    } state_e;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/soc_hash_host_if.sv
// Upstream message / downstream digest byte streams of soc_hash_host.
//
// Handshake rule for both streams: a byte transfers on a rising clk edge
// where valid and ready are both 1. The source holds valid and data stable
// until that transfer; valid never drops without a transfer. The sink may
// change ready freely.
interface soc_hash_host_if;
    import soc_hash_host_pkg::*;

    logic              msg_valid;
    logic              msg_ready;
    logic [BYTE_W-1:0] msg_data;
    logic              dig_valid;
    logic              dig_ready;
    logic [BYTE_W-1:0] dig_data;

    modport slave (
        input  msg_valid, msg_data, dig_ready,
        output msg_ready, dig_valid, dig_data
    );

    modport master (
        output msg_valid, msg_data, dig_ready,
        input  msg_ready, dig_valid, dig_data
    );

endinterface

// File: rtl/soc_hash_host.sv
// soc_hash_host: streams a message into a byte-wide hashing core, starts it,
// waits for completion and streams the digest back out, one byte per
// handshake. Optional watchdog on the GUARD+WAIT phase is enabled by
// defining SOC_HASH_HOST_TIMEOUT_EN.
module soc_hash_host
    import soc_hash_host_pkg::*;
#(
    parameter int MSG_BYTES = DEF_MSG_BYTES,
    parameter int DIG_BYTES = DEF_DIG_BYTES,
    parameter int GUARD     = DEF_GUARD,
    parameter int TMO       = DEF_TMO
) (
    input  logic                clk,
    input  logic                rst,
    soc_hash_host_if.slave      bus,
    output logic                reg_inputxSO,
    output logic [BYTE_W-1:0]   messagexSO,
    output logic                reg_startxSO,
    output logic                hash_startxSO,
    input  logic                hash_readyxSI,
    input  logic [BYTE_W-1:0]   hash_digestxSI,
    output logic                reg_outxSO,
    output logic                busy,
    output logic                err,
    output logic [3:0]          o_dbg_state
);

    localparam logic [3:0] S_IDLE    = ST_IDLE;
    localparam logic [3:0] S_LOAD    = ST_LOAD;
    localparam logic [3:0] S_START   = ST_START;
    localparam logic [3:0] S_GUARD   = ST_GUARD;
    localparam logic [3:0] S_WAIT    = ST_WAIT;
    localparam logic [3:0] S_RD_REQ  = ST_RD_REQ;
    localparam logic [3:0] S_RD_CAP  = ST_RD_CAP;
    localparam logic [3:0] S_RD_PUSH = ST_RD_PUSH;
    localparam logic [3:0] S_WRAP    = ST_WRAP;
    localparam logic [3:0] S_ERR     = ST_ERR;

    // One counter serves both the load and the read phase; it is back at 0
    // whenever a phase finishes, so it never wraps inside a transaction.
    localparam int CNT_W = $clog2(max_int(MSG_BYTES, DIG_BYTES) + 1);
    localparam logic [CNT_W-1:0] MSG_LAST = CNT_W'(MSG_BYTES - 1);
    localparam logic [CNT_W-1:0] DIG_LAST = CNT_W'(DIG_BYTES - 1);

    localparam int GRD_W = $clog2(GUARD + 2);
    localparam logic [GRD_W-1:0] GRD_LAST = GRD_W'((GUARD > 0) ? GUARD - 1 : 0);

    logic [3:0]        r_state;
    logic [3:0]        w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic [GRD_W-1:0]  r_gcnt;
    logic [BYTE_W-1:0] r_dig;
    logic              w_msg_fire;
    logic              w_dig_fire;
    logic              w_tmo_hit;

    assign w_msg_fire = (r_state == S_LOAD) && bus.msg_valid;
    assign w_dig_fire = (r_state == S_RD_PUSH) && bus.dig_ready;

`ifdef SOC_HASH_HOST_TIMEOUT_EN
    localparam int TMO_W = $clog2(TMO + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO - 1);

    logic [TMO_W-1:0] r_tmo;

    assign w_tmo_hit = ((r_state == S_GUARD) || (r_state == S_WAIT)) && (r_tmo == TMO_LAST);
    assign err       = (r_state == S_ERR);

    // Watchdog: counts every cycle spent in GUARD or WAIT, restarted by START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_tmo <= '0;
        end else if (r_state == S_START) begin
            r_tmo <= '0;
        end else if (((r_state == S_GUARD) || (r_state == S_WAIT)) && !w_tmo_hit) begin
            r_tmo <= r_tmo + TMO_W'(1);
        end
    end
`else
    assign w_tmo_hit = 1'b0;
    assign err       = 1'b0;
`endif

    // Next-state decode; a watchdog expiry overrides everything except a
    // completion seen in the same WAIT cycle.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:    if (bus.msg_valid) w_state_nxt = S_LOAD;
            S_LOAD:    if (w_msg_fire && (r_cnt == MSG_LAST)) w_state_nxt = S_START;
            S_START:   w_state_nxt = (GUARD == 0) ? S_WAIT : S_GUARD;
            S_GUARD:   if (r_gcnt == GRD_LAST) w_state_nxt = S_WAIT;
            S_WAIT:    if (hash_readyxSI) w_state_nxt = S_RD_REQ;
            S_RD_REQ:  w_state_nxt = S_RD_CAP;
            S_RD_CAP:  w_state_nxt = S_RD_PUSH;
            S_RD_PUSH: if (w_dig_fire) w_state_nxt = (r_cnt == DIG_LAST) ? S_WRAP : S_RD_REQ;
            S_WRAP:    w_state_nxt = S_IDLE;
            S_ERR:     w_state_nxt = S_ERR;
            default:   w_state_nxt = S_IDLE;
        endcase
        if (w_tmo_hit && !((r_state == S_WAIT) && hash_readyxSI)) begin
            w_state_nxt = S_ERR;
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Shared byte counter: message bytes during LOAD, digest bytes during reads.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_state == S_IDLE) begin
            r_cnt <= '0;
        end else if (w_msg_fire) begin
            r_cnt <= (r_cnt == MSG_LAST) ? '0 : r_cnt + CNT_W'(1);
        end else if (w_dig_fire) begin
            r_cnt <= (r_cnt == DIG_LAST) ? '0 : r_cnt + CNT_W'(1);
        end
    end

    // Guard counter: hash_readyxSI is ignored until GUARD cycles after START.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_gcnt <= '0;
        end else if (r_state == S_START) begin
            r_gcnt <= '0;
        end else if (r_state == S_GUARD) begin
            r_gcnt <= r_gcnt + GRD_W'(1);
        end
    end

    // Digest byte capture, one cycle after the read strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dig <= '0;
        end else if (r_state == S_RD_CAP) begin
            r_dig <= hash_digestxSI;
        end
    end

    // Strobes decode from disjoint states, so they can never overlap.
    assign bus.msg_ready  = (r_state == S_LOAD);
    assign reg_inputxSO   = w_msg_fire;
    assign messagexSO     = w_msg_fire ? bus.msg_data : '0;
    assign reg_startxSO   = (r_state == S_START);
    assign hash_startxSO  = (r_state == S_START);
    assign reg_outxSO     = (r_state == S_RD_REQ) || (r_state == S_WRAP);
    assign bus.dig_valid  = (r_state == S_RD_PUSH);
    assign bus.dig_data   = r_dig;
    assign busy           = (r_state != S_IDLE);
    assign o_dbg_state    = r_state;

endmodule

// File: tb/tb_soc_hash_host.sv
// Bench for soc_hash_host: byte-wide hashing core model, random downstream
// back-pressure, digest scoreboard. Covers the watchdog in either build of
// SOC_HASH_HOST_TIMEOUT_EN.
module tb_soc_hash_host;
    import soc_hash_host_pkg::*;

    localparam int MSG   = 32;
    localparam int DIG   = 32;
    localparam int GRD   = 2;
    localparam int TMO_C = 64;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- DUT ----------------
    soc_hash_host_if u_if();

    logic       reg_inputxSO;
    logic [7:0] messagexSO;
    logic       reg_startxSO;
    logic       hash_startxSO;
    logic       hash_readyxSI;
    logic [7:0] hash_digestxSI;
    logic       reg_outxSO;
    logic       busy;
    logic       err;
    logic [3:0] dbg_state;

    soc_hash_host #(
        .MSG_BYTES (MSG),
        .DIG_BYTES (DIG),
        .GUARD     (GRD),
        .TMO       (TMO_C)
    ) u_dut (
        .clk            (clk),
        .rst            (rst),
        .bus            (u_if),
        .reg_inputxSO   (reg_inputxSO),
        .messagexSO     (messagexSO),
        .reg_startxSO   (reg_startxSO),
        .hash_startxSO  (hash_startxSO),
        .hash_readyxSI  (hash_readyxSI),
        .hash_digestxSI (hash_digestxSI),
        .reg_outxSO     (reg_outxSO),
        .busy           (busy),
        .err            (err),
        .o_dbg_state    (dbg_state)
    );

    // ---------------- checking ----------------
    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Reference digest of a message, as produced by the core model.
    function automatic logic [7:0] hfun(input logic [7:0] m [0:31], input int i);
        logic [7:0] k;
        k = 8'(i * 37 + 11);
        return m[31 - i] ^ {m[i][3:0], m[i][7:4]} ^ k;
    endfunction

    // ---------------- hashing core model ----------------
    logic [7:0] cmem [0:31];
    logic [7:0] dmem [0:31];
    int  wptr, rptr, timer;
    bit  core_sticky = 0;
    bit  core_never  = 0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= 0; rptr <= 0; timer <= 0;
            hash_readyxSI <= 1'b0; hash_digestxSI <= 8'h00;
        end else begin
            if (reg_inputxSO && wptr < 32) begin
                cmem[wptr] <= messagexSO;
                wptr <= wptr + 1;
            end
            if (reg_startxSO) begin
                wptr <= 0;
                for (int i = 0; i < 32; i++) dmem[i] <= hfun(cmem, i);
                timer <= 20;
                if (!core_sticky) hash_readyxSI <= 1'b0;
            end else if (timer > 0) begin
                timer <= timer - 1;
                if (timer == 1 && !core_never) hash_readyxSI <= 1'b1;
            end
            if (reg_outxSO) begin
                hash_digestxSI <= (rptr < 32) ? dmem[rptr] : 8'h00;
                rptr <= (rptr >= 32) ? 0 : rptr + 1;
            end
        end
    end

    // ---------------- scoreboard / monitor ----------------
    logic [7:0] exp_q [$];
    int n_in, n_start, n_rd, dig_idx;
    int first_acc_cyc, first_dig_cyc, start_cyc, first_rd_cyc, err_cyc;
    int excl_viol = 0;
    bit stall_mode = 0;
    int stall_left = 0;
    bit stall_watch = 0;
    logic [7:0] stall_held = 8'h00;
    int stall_seen, stall_viol;

    task automatic clear_stats();
        n_in = 0; n_start = 0; n_rd = 0; dig_idx = 0;
        first_acc_cyc = -1; first_dig_cyc = -1; start_cyc = -1;
        first_rd_cyc = -1; err_cyc = -1;
        stall_seen = 0; stall_viol = 0;
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if ((int'(reg_inputxSO) + int'(reg_outxSO) + int'(reg_startxSO)) > 1 ||
                reg_startxSO != hash_startxSO) excl_viol++;
            if (reg_inputxSO) begin
                n_in++;
                if (first_acc_cyc < 0) first_acc_cyc = cyc;
            end
            if (reg_startxSO) begin
                n_start++;
                start_cyc = cyc;
            end
            if (reg_outxSO) begin
                n_rd++;
                if (first_rd_cyc < 0) first_rd_cyc = cyc;
            end
            if (u_if.dig_valid && first_dig_cyc < 0) first_dig_cyc = cyc;
            if (err && err_cyc < 0) err_cyc = cyc;
            if (stall_watch) begin
                stall_seen++;
                if (!u_if.dig_valid || u_if.dig_data != stall_held || reg_outxSO) stall_viol++;
            end
            if (u_if.dig_valid && u_if.dig_ready) begin
                if (exp_q.size() > 0) check("dig_data", u_if.dig_data, exp_q.pop_front());
                else check("dig_unexpected", 1, 0);
                dig_idx++;
            end
        end
    end

    // ---------------- drivers ----------------
    // Downstream sink: random ready, or a 10-cycle stall while byte 5 is offered.
    initial begin
        u_if.dig_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            if (stall_mode && stall_left > 0 && dig_idx == 5 && u_if.dig_valid) begin
                if (!stall_watch) stall_held = u_if.dig_data;
                stall_watch = 1;
                u_if.dig_ready = 1'b0;
                stall_left--;
            end else begin
                stall_watch = 0;
                u_if.dig_ready = ($urandom_range(0, 3) != 0);
            end
        end
    end

    task automatic send_bytes(input logic [7:0] m [0:31], input int n);
        for (int i = 0; i < n; i++) begin
            int gap;
            int w;
            bit acc;
            gap = $urandom_range(0, 2);
            repeat (gap) begin @(posedge clk); #1; end
            u_if.msg_valid = 1'b1;
            u_if.msg_data  = m[i];
            acc = 0;
            w = 0;
            while (!acc && w < 2000) begin
                @(negedge clk);
                acc = u_if.msg_ready;
                @(posedge clk); #1;
                w++;
            end
            if (!acc) check("msg_accept_bound", 0, 1);
            u_if.msg_valid = 1'b0;
            u_if.msg_data  = 8'h00;
        end
    endtask

    task automatic push_exp(input logic [7:0] m [0:31]);
        for (int i = 0; i < DIG; i++) exp_q.push_back(hfun(m, i));
    endtask

    task automatic wait_idle(input int budget);
        int i;
        for (i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy && exp_q.size() == 0) break;
        end
        check("idle_reached", (i < budget), 1);
    endtask

    task automatic run_one(input logic [7:0] m [0:31]);
        clear_stats();
        push_exp(m);
        send_bytes(m, MSG);
        wait_idle(3000);
        check("n_reg_input", n_in, MSG);
        check("n_start", n_start, 1);
        check("n_reg_out", n_rd, DIG + 1);
    endtask

    // ---------------- main sequence ----------------
    logic [7:0] ma [0:31];
    logic [7:0] mb [0:31];

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "bench time limit");
    end

    initial begin
        u_if.msg_valid = 1'b1;
        u_if.msg_data  = 8'hAA;
        clear_stats();

        // reset state, with a message byte already offered
        repeat (3) @(negedge clk);
        check("rst_msg_ready", u_if.msg_ready, 0);
        check("rst_dig_valid", u_if.dig_valid, 0);
        check("rst_dig_data", u_if.dig_data, 0);
        check("rst_messagexSO", messagexSO, 0);
        check("rst_strobes", {reg_inputxSO, reg_startxSO, hash_startxSO, reg_outxSO}, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);
        u_if.msg_valid = 1'b0;
        u_if.msg_data  = 8'h00;
        @(posedge clk); #1;
        rst = 1'b0;

        // counting message, latency
        for (int i = 0; i < 32; i++) ma[i] = 8'(i);
        run_one(ma);
        check("lat_ge_min", ((first_dig_cyc - first_acc_cyc) >= MSG + GRD + 3), 1);

        // downstream stall on byte 5
        for (int i = 0; i < 32; i++) ma[i] = 8'($urandom_range(0, 255));
        stall_mode = 1;
        stall_left = 10;
        run_one(ma);
        stall_mode = 0;
        check("stall_cycles", stall_seen, 10);
        check("stall_stable", stall_viol, 0);

        // hash_readyxSI still high from the previous hash
        core_sticky = 1;
        for (int i = 0; i < 32; i++) ma[i] = 8'($urandom_range(0, 255));
        run_one(ma);
        core_sticky = 0;
        check("guard_to_read", first_rd_cyc - start_cyc, GRD + 2);

        // asynchronous reset in the middle of a load
        clear_stats();
        for (int i = 0; i < 32; i++) ma[i] = 8'($urandom_range(0, 255));
        send_bytes(ma, 12);
        check("partial_n_in", n_in, 12);
        u_if.msg_valid = 1'b1;
        u_if.msg_data  = 8'hEE;
        @(negedge clk);
        check("pre_rst_messagexSO", messagexSO, 8'hEE);
        #2 rst = 1'b1;
        #1;
        check("async_busy", busy, 0);
        check("async_msg_ready", u_if.msg_ready, 0);
        check("async_messagexSO", messagexSO, 0);
        check("async_reg_input", reg_inputxSO, 0);
        check("async_state", dbg_state, 4'(ST_IDLE));
        u_if.msg_valid = 1'b0;
        u_if.msg_data  = 8'h00;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 32; i++) ma[i] = 8'($urandom_range(0, 255));
        run_one(ma);

        // back-to-back: second message offered while the first is still busy
        clear_stats();
        for (int i = 0; i < 32; i++) begin
            ma[i] = 8'($urandom_range(0, 255));
            mb[i] = 8'($urandom_range(0, 255));
        end
        push_exp(ma);
        push_exp(mb);
        send_bytes(ma, MSG);
        send_bytes(mb, MSG);
        wait_idle(6000);
        check("b2b_n_in", n_in, 2 * MSG);
        check("b2b_n_start", n_start, 2);
        check("b2b_n_reg_out", n_rd, 2 * (DIG + 1));
        check("strobe_excl", excl_viol, 0);

        // core never completes
        clear_stats();
        core_never = 1;
        for (int i = 0; i < 32; i++) ma[i] = 8'($urandom_range(0, 255));
        send_bytes(ma, MSG);
`ifdef SOC_HASH_HOST_TIMEOUT_EN
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (err) break;
        end
        check("tmo_err", err, 1);
        check("tmo_err_cycle", err_cyc - start_cyc, TMO_C + 1);
        repeat (20) @(negedge clk);
        check("tmo_err_held", err, 1);
        check("tmo_busy", busy, 1);
        check("tmo_strobes", {reg_inputxSO, reg_startxSO, hash_startxSO, reg_outxSO}, 0);
`else
        repeat (200) @(negedge clk);
        check("notmo_err", err, 0);
        check("notmo_busy", busy, 1);
        check("notmo_state", dbg_state, 4'(ST_WAIT));
`endif
        check("stuck_no_read", n_rd, 0);
        @(posedge clk); #1 rst = 1'b1;
        core_never = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("final_err", err, 0);
        check("final_busy", busy, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
